serpent_spawner: RTL and testbench
==================================

// Module: serpent_spawner
// PURPOSE
//  Upstream spawn controller for serpent_layer. Decides when a new purple ball/serpent enters the pyramid.
//  Generates its 5-step random descent pattern and its entry cube, then drives e_enable_sp/e_move_sp/e_XY0_sp.
//  Tracks the serpent's life (sp_state/sp_end) and re-arms after a delay. Obeys game pause/restart, KO and level end.
// PARAMETERS
//  LFSR_SEED    16'hACE1  non-zero LFSR reset value
//  FIRST_DELAY  32'd100_000_000  WAIT length (cycles) after game start/restart
//  SPAWN_DELAY  32'd50_000_000   WAIT length after serpent end, KO or arm timeout
//  ARM_TIMEOUT  32'd1_000_000    max cycles e_enable_sp is held without sp_state acknowledge
//  XY_LEFT      21'h0            {x[10:0],y[9:0]} of left row-2 entry cube
//  XY_RIGHT     21'h0            {x[10:0],y[9:0]} of right row-2 entry cube
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  e_start_qb   in   1   game start / restart request
//  e_pause_qb   in   1   pause request
//  e_resume_qb  in   1   resume request
//  KO_qb        in   1   Q*bert killed
//  done_move_sc in   1   level complete
//  freeze_power in   1   freeze bonus active, stalls WAIT countdown
//  sp_state     in   1   serpent_layer active (1 = serpent on screen)
//  sp_end       in   1   serpent_layer finished sequence
//  e_enable_sp  out  1   spawn request, level, to serpent_layer
//  e_move_sp    out  5   descent pattern, bit i = direction of move i (0 up-right, 1 down-right)
//  e_XY0_sp     out  21  entry cube {x,y}
//  spawn_cnt    out  8   serpents completed since start, saturates at 255
//  spawner_st   out  3   current FSM state, debug
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, game=RESUME, lfsr=LFSR_SEED, delay/timeout counters=0, all outputs 0.
//  LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts every cycle out of reset incl. pause; never 0.
//  Game layer, highest priority after reset:
//   - RESUME: e_pause_qb -> PAUSE.
//   - PAUSE: all FSM regs/counters frozen, e_enable_sp forced 0. e_resume_qb -> RESUME, FSM unchanged.
//     Else e_start_qb -> restart: FSM=WAIT, delay=FIRST_DELAY, spawn_cnt=0, game=RESUME.
//  FSM, evaluated only in RESUME. Priority: done_move_sc > KO_qb > sp_end > local condition.
//   IDLE:   e_start_qb -> WAIT, delay=FIRST_DELAY.
//   WAIT:   freeze_power=1 holds delay. Else delay--. Exit to ARM when delay==1 and decrementing (WAIT lasts exactly D unfrozen cycles).
//           On exit: e_move_sp<=lfsr[4:0]; e_XY0_sp<=lfsr[5]?XY_RIGHT:XY_LEFT; timeout=0.
//   ARM:    e_enable_sp=1 (registered, first high cycle = first ARM cycle). Pattern/XY stable while armed.
//           sp_state==1 -> ACTIVE, enable drops next cycle.
//           timeout reaches ARM_TIMEOUT-1 -> WAIT, delay=SPAWN_DELAY (retry, new pattern).
//   ACTIVE: e_enable_sp=0. Rising edge of sp_end (registered history) -> WAIT, delay=SPAWN_DELAY, spawn_cnt+1 sat.
//  Global events in any FSM state except IDLE:
//   - done_move_sc=1 -> IDLE, e_enable_sp=0. Wait for new e_start_qb.
//   - KO_qb=1 -> WAIT, delay=SPAWN_DELAY, e_enable_sp=0; spawn_cnt unchanged.
//  Events arriving together: e_pause_qb beats everything; KO and sp_end in same cycle -> KO handling only.
//  e_move_sp/e_XY0_sp change only on WAIT->ARM; otherwise hold (incl. reset to 0).
//  Delay counter 32-bit unsigned, loaded value 0 treated as 1.
// TESTING (bench params: FIRST_DELAY=10, SPAWN_DELAY=20, ARM_TIMEOUT=8)
//  1. Release reset, e_start_qb pulse at t0 -> e_enable_sp rises exactly 10 cycles later.
//     e_move_sp==lfsr[4:0] sampled at exit; XY matches lfsr[5].
//  2. ARM, sp_state high at cycle 3 -> enable falls next cycle.
//     sp_end pulse -> spawn_cnt 0->1, enable again after 20 cycles.
//  3. ARM with sp_state held 0 -> enable drops after 8 cycles, re-rises 20 later with next LFSR pattern.
//  4. WAIT with freeze_power high 5 cycles -> spawn delayed by exactly 5 cycles.
//  5. e_pause_qb mid-WAIT, hold 30 cycles, e_resume_qb -> remaining delay preserved.
//     e_start_qb in PAUSE instead -> spawn_cnt=0, 10-cycle delay.
//  6. KO_qb and sp_end same cycle in ACTIVE -> spawn_cnt unchanged, WAIT 20.
//     done_move_sc -> IDLE, no enable until e_start_qb. Async reset mid-ARM -> enable 0 immediately.

Source files
------------

// File: rtl/serpent_spawner.sv
// Spawn controller for serpent_layer: decides when a serpent enters the pyramid,
// picks its 5-step descent pattern and entry cube from an LFSR, tracks its life
// and re-arms after a delay. Honours game pause/resume/restart, KO and level end.
// Ports:
//   clk, reset (async, active-low)
//   e_start_qb, e_pause_qb, e_resume_qb : game control requests
//   KO_qb, done_move_sc                 : Q*bert killed / level complete
//   freeze_power                        : stalls the WAIT countdown
//   sp_state, sp_end                    : serpent_layer active / sequence finished
//   e_enable_sp, e_move_sp, e_XY0_sp    : spawn request, descent pattern, entry cube
//   spawn_cnt                           : completed serpents since start (saturating)
//   spawner_st                          : current FSM state (debug)
module serpent_spawner #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [31:0] FIRST_DELAY = 32'd100_000_000,
  parameter logic [31:0] SPAWN_DELAY = 32'd50_000_000,
  parameter logic [31:0] ARM_TIMEOUT = 32'd1_000_000,
  parameter logic [20:0] XY_LEFT     = 21'h0,
  parameter logic [20:0] XY_RIGHT    = 21'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_start_qb,
  input  logic        e_pause_qb,
  input  logic        e_resume_qb,
  input  logic        KO_qb,
  input  logic        done_move_sc,
  input  logic        freeze_power,
  input  logic        sp_state,
  input  logic        sp_end,
  output logic        e_enable_sp,
  output logic [4:0]  e_move_sp,
  output logic [20:0] e_XY0_sp,
  output logic [7:0]  spawn_cnt,
  output logic [2:0]  spawner_st
);

  localparam int unsigned LfsrW = 16;
  localparam int unsigned DlyW  = 32;
  localparam int unsigned MoveW = 5;
  localparam int unsigned XyW   = 21;
  localparam int unsigned CntW  = 8;

  // A zero delay load behaves as a one-cycle WAIT.
  localparam logic [DlyW-1:0] FirstLoad   = (FIRST_DELAY == 32'd0) ? 32'd1 : FIRST_DELAY;
  localparam logic [DlyW-1:0] SpawnLoad   = (SPAWN_DELAY == 32'd0) ? 32'd1 : SPAWN_DELAY;
  localparam logic [DlyW-1:0] TimeoutLast = (ARM_TIMEOUT == 32'd0) ? 32'd0 : ARM_TIMEOUT - 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ARM    = 3'd2,
    ST_ACTIVE = 3'd3
  } state_e;

  typedef enum logic {
    GAME_RESUME = 1'b0,
    GAME_PAUSE  = 1'b1
  } game_e;

  state_e           state_q, state_d;
  game_e            game_q, game_d;
  logic [LfsrW-1:0] lfsr_q, lfsr_d;
  logic [DlyW-1:0]  delay_q, delay_d;
  logic [DlyW-1:0]  timeout_q, timeout_d;
  logic [MoveW-1:0] move_q, move_d;
  logic [XyW-1:0]   xy_q, xy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             sp_end_q, sp_end_d;
  logic             sp_end_rise;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      game_q    <= GAME_RESUME;
      lfsr_q    <= LFSR_SEED;
      delay_q   <= '0;
      timeout_q <= '0;
      move_q    <= '0;
      xy_q      <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      sp_end_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      game_q    <= game_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      timeout_q <= timeout_d;
      move_q    <= move_d;
      xy_q      <= xy_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      sp_end_q  <= sp_end_d;
    end
  end

  assign sp_end_rise = sp_end & ~sp_end_q;

  // Game layer, global events and spawn FSM
  always_comb begin
    state_d   = state_q;
    game_d    = game_q;
    delay_d   = delay_q;
    timeout_d = timeout_q;
    move_d    = move_q;
    xy_d      = xy_q;
    cnt_d     = cnt_q;
    en_d      = 1'b0;
    sp_end_d  = sp_end;
    // Fibonacci taps 16,14,13,11; the LFSR runs even while paused
    lfsr_d    = {lfsr_q[LfsrW-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    if (game_q == GAME_PAUSE) begin
      if (e_resume_qb) begin
        game_d = GAME_RESUME;
        en_d   = (state_q == ST_ARM);
      end else if (e_start_qb) begin
        game_d  = GAME_RESUME;
        state_d = ST_WAIT;
        delay_d = FirstLoad;
        cnt_d   = '0;
      end
    end else if (e_pause_qb) begin
      game_d = GAME_PAUSE;
    end else begin
      if (state_q != ST_IDLE && done_move_sc) begin
        state_d = ST_IDLE;
      end else if (state_q != ST_IDLE && KO_qb) begin
        state_d = ST_WAIT;
        delay_d = SpawnLoad;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (e_start_qb) begin
              state_d = ST_WAIT;
              delay_d = FirstLoad;
            end
          end
          ST_WAIT: begin
            if (!freeze_power) begin
              if (delay_q <= 32'd1) begin
                state_d   = ST_ARM;
                move_d    = lfsr_q[MoveW-1:0];
                xy_d      = lfsr_q[5] ? XY_RIGHT : XY_LEFT;
                timeout_d = '0;
              end else begin
                delay_d = DlyW'(delay_q - 32'd1);
              end
            end
          end
          ST_ARM: begin
            if (sp_state) begin
              state_d = ST_ACTIVE;
            end else if (timeout_q >= TimeoutLast) begin
              state_d = ST_WAIT;
              delay_d = SpawnLoad;
            end else begin
              timeout_d = DlyW'(timeout_q + 32'd1);
            end
          end
          ST_ACTIVE: begin
            if (sp_end_rise) begin
              state_d = ST_WAIT;
              delay_d = SpawnLoad;
              cnt_d   = (cnt_q == 8'hFF) ? cnt_q : CntW'(cnt_q + 8'd1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      en_d = (state_d == ST_ARM);
    end
  end

  assign e_enable_sp = en_q;
  assign e_move_sp   = move_q;
  assign e_XY0_sp    = xy_q;
  assign spawn_cnt   = cnt_q;
  assign spawner_st  = 3'(state_q);

endmodule

// File: tb/tb_serpent_spawner.sv
// Directed bench for serpent_spawner with short delays (10/20/8).
module tb_serpent_spawner;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [20:0] XY_L  = 21'h12345;
  localparam logic [20:0] XY_R  = 21'h0ABCD;

  logic        clk;
  logic        reset;
  logic        e_start_qb, e_pause_qb, e_resume_qb, KO_qb, done_move_sc;
  logic        freeze_power, sp_state, sp_end;
  logic        e_enable_sp;
  logic [4:0]  e_move_sp;
  logic [20:0] e_XY0_sp;
  logic [7:0]  spawn_cnt;
  logic [2:0]  spawner_st;

  int total = 0;
  int bad   = 0;

  // Reference LFSR; m_prev holds the value the DUT saw at the last edge
  logic [15:0] m_lfsr, m_prev;

  serpent_spawner #(
    .LFSR_SEED  (SEED),
    .FIRST_DELAY(32'd10),
    .SPAWN_DELAY(32'd20),
    .ARM_TIMEOUT(32'd8),
    .XY_LEFT    (XY_L),
    .XY_RIGHT   (XY_R)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .e_start_qb  (e_start_qb),
    .e_pause_qb  (e_pause_qb),
    .e_resume_qb (e_resume_qb),
    .KO_qb       (KO_qb),
    .done_move_sc(done_move_sc),
    .freeze_power(freeze_power),
    .sp_state    (sp_state),
    .sp_end      (sp_end),
    .e_enable_sp (e_enable_sp),
    .e_move_sp   (e_move_sp),
    .e_XY0_sp    (e_XY0_sp),
    .spawn_cnt   (spawn_cnt),
    .spawner_st  (spawner_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Cycles until e_enable_sp reaches level; -1 if the budget expires
  task automatic wait_en(input logic level, input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (e_enable_sp === level) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    e_start_qb = 1'b1; tick(); e_start_qb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ticks(2);
    total++; if (e_enable_sp !== 1'b0) begin bad++; $display("FAIL reset_en got=%0h want=0", e_enable_sp); end
    total++; if (e_move_sp !== 5'd0) begin bad++; $display("FAIL reset_move got=%0h want=0", e_move_sp); end
    total++; if (e_XY0_sp !== 21'd0) begin bad++; $display("FAIL reset_xy got=%0h want=0", e_XY0_sp); end
    total++; if (spawn_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", spawn_cnt); end
    total++; if (spawner_st !== 3'd0) begin bad++; $display("FAIL reset_st got=%0d want=0", spawner_st); end
    reset = 1'b1;
    ticks(3);
    total++; if (e_enable_sp !== 1'b0) begin bad++; $display("FAIL idle_no_en got=%0h want=0", e_enable_sp); end
  endtask

  task automatic test_first_spawn();
    int n;
    logic [20:0] xy_exp;
    pulse_start();
    total++; if (spawner_st !== 3'd1) begin bad++; $display("FAIL start_wait_st got=%0d want=1", spawner_st); end
    wait_en(1'b1, 30, n);
    total++; if (n !== 10) begin bad++; $display("FAIL first_delay got=%0d want=10", n); end
    xy_exp = m_prev[5] ? XY_R : XY_L;
    total++; if (e_move_sp !== m_prev[4:0]) begin bad++; $display("FAIL first_move got=%0h want=%0h", e_move_sp, m_prev[4:0]); end
    total++; if (e_XY0_sp !== xy_exp) begin bad++; $display("FAIL first_xy got=%0h want=%0h", e_XY0_sp, xy_exp); end
    total++; if (spawner_st !== 3'd2) begin bad++; $display("FAIL arm_st got=%0d want=2", spawner_st); end
  endtask

  task automatic test_ack_and_end();
    int n;
    logic [4:0] mv;
    mv = e_move_sp;
    ticks(2);
    total++; if (e_enable_sp !== 1'b1) begin bad++; $display("FAIL arm_hold_en got=%0h want=1", e_enable_sp); end
    total++; if (e_move_sp !== mv) begin bad++; $display("FAIL arm_move_stable got=%0h want=%0h", e_move_sp, mv); end
    sp_state = 1'b1; tick();
    total++; if (e_enable_sp !== 1'b0) begin bad++; $display("FAIL ack_en_drop got=%0h want=0", e_enable_sp); end
    total++; if (spawner_st !== 3'd3) begin bad++; $display("FAIL active_st got=%0d want=3", spawner_st); end
    ticks(4);
    sp_end = 1'b1; tick(); sp_end = 1'b0; sp_state = 1'b0;
    total++; if (spawn_cnt !== 8'd1) begin bad++; $display("FAIL end_cnt got=%0d want=1", spawn_cnt); end
    total++; if (spawner_st !== 3'd1) begin bad++; $display("FAIL end_wait_st got=%0d want=1", spawner_st); end
    wait_en(1'b1, 40, n);
    total++; if (n !== 20) begin bad++; $display("FAIL spawn_delay got=%0d want=20", n); end
    total++; if (e_move_sp !== m_prev[4:0]) begin bad++; $display("FAIL second_move got=%0h want=%0h", e_move_sp, m_prev[4:0]); end
  endtask

  task automatic test_timeout();
    int n;
    logic [20:0] xy_exp;
    wait_en(1'b0, 20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL timeout_len got=%0d want=8", n); end
    wait_en(1'b1, 40, n);
    total++; if (n !== 20) begin bad++; $display("FAIL retry_delay got=%0d want=20", n); end
    xy_exp = m_prev[5] ? XY_R : XY_L;
    total++; if (e_move_sp !== m_prev[4:0]) begin bad++; $display("FAIL retry_move got=%0h want=%0h", e_move_sp, m_prev[4:0]); end
    total++; if (e_XY0_sp !== xy_exp) begin bad++; $display("FAIL retry_xy got=%0h want=%0h", e_XY0_sp, xy_exp); end
  endtask

  task automatic test_freeze();
    int n;
    wait_en(1'b0, 20, n);
    total++; if (n !== 8) begin bad++; $display("FAIL freeze_prep got=%0d want=8", n); end
    ticks(3);
    freeze_power = 1'b1; ticks(5); freeze_power = 1'b0;
    wait_en(1'b1, 40, n);
    total++; if (n !== 17) begin bad++; $display("FAIL freeze_remaining got=%0d want=17", n); end
  endtask

  task automatic test_pause();
    int n;
    wait_en(1'b0, 20, n);
    ticks(5);
    e_pause_qb = 1'b1; tick(); e_pause_qb = 1'b0;
    ticks(30);
    total++; if (spawner_st !== 3'd1) begin bad++; $display("FAIL pause_st got=%0d want=1", spawner_st); end
    e_resume_qb = 1'b1; tick(); e_resume_qb = 1'b0;
    wait_en(1'b1, 40, n);
    total++; if (n !== 15) begin bad++; $display("FAIL pause_remaining got=%0d want=15", n); end
    // Pause while armed forces enable low
    e_pause_qb = 1'b1; tick(); e_pause_qb = 1'b0;
    total++; if (e_enable_sp !== 1'b0) begin bad++; $display("FAIL pause_arm_en got=%0h want=0", e_enable_sp); end
    total++; if (spawner_st !== 3'd2) begin bad++; $display("FAIL pause_arm_st got=%0d want=2", spawner_st); end
    ticks(3);
    pulse_start();
    total++; if (spawn_cnt !== 8'd0) begin bad++; $display("FAIL restart_cnt got=%0d want=0", spawn_cnt); end
    total++; if (spawner_st !== 3'd1) begin bad++; $display("FAIL restart_st got=%0d want=1", spawner_st); end
    wait_en(1'b1, 30, n);
    total++; if (n !== 10) begin bad++; $display("FAIL restart_delay got=%0d want=10", n); end
  endtask

  task automatic test_ko_with_end();
    int n;
    sp_state = 1'b1; tick();
    sp_end = 1'b1; tick(); sp_end = 1'b0; sp_state = 1'b0;
    total++; if (spawn_cnt !== 8'd1) begin bad++; $display("FAIL ko_prep_cnt got=%0d want=1", spawn_cnt); end
    wait_en(1'b1, 40, n);
    sp_state = 1'b1; tick(); sp_state = 1'b0;
    ticks(2);
    KO_qb = 1'b1; sp_end = 1'b1; tick(); KO_qb = 1'b0; sp_end = 1'b0;
    total++; if (spawn_cnt !== 8'd1) begin bad++; $display("FAIL ko_cnt got=%0d want=1", spawn_cnt); end
    total++; if (spawner_st !== 3'd1) begin bad++; $display("FAIL ko_st got=%0d want=1", spawner_st); end
    wait_en(1'b1, 40, n);
    total++; if (n !== 20) begin bad++; $display("FAIL ko_delay got=%0d want=20", n); end
  endtask

  task automatic test_done();
    int n;
    done_move_sc = 1'b1; tick(); done_move_sc = 1'b0;
    total++; if (e_enable_sp !== 1'b0) begin bad++; $display("FAIL done_en got=%0h want=0", e_enable_sp); end
    total++; if (spawner_st !== 3'd0) begin bad++; $display("FAIL done_st got=%0d want=0", spawner_st); end
    wait_en(1'b1, 50, n);
    total++; if (n !== -1) begin bad++; $display("FAIL done_idle got=%0d want=-1", n); end
    pulse_start();
    wait_en(1'b1, 30, n);
    total++; if (n !== 10) begin bad++; $display("FAIL done_restart got=%0d want=10", n); end
  endtask

  task automatic test_async_reset();
    total++; if (e_enable_sp !== 1'b1) begin bad++; $display("FAIL pre_reset_en got=%0h want=1", e_enable_sp); end
    #2 reset = 1'b0;
    #1;
    total++; if (e_enable_sp !== 1'b0) begin bad++; $display("FAIL async_en got=%0h want=0", e_enable_sp); end
    total++; if (spawn_cnt !== 8'd0) begin bad++; $display("FAIL async_cnt got=%0d want=0", spawn_cnt); end
    total++; if (spawner_st !== 3'd0) begin bad++; $display("FAIL async_st got=%0d want=0", spawner_st); end
    total++; if (e_move_sp !== 5'd0) begin bad++; $display("FAIL async_move got=%0h want=0", e_move_sp); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    e_start_qb = 1'b0; e_pause_qb = 1'b0; e_resume_qb = 1'b0;
    KO_qb = 1'b0; done_move_sc = 1'b0; freeze_power = 1'b0;
    sp_state = 1'b0; sp_end = 1'b0;
    test_reset();
    test_first_spawn();
    test_ack_and_end();
    test_timeout();
    test_freeze();
    test_pause();
    test_ko_with_end();
    test_done();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
